// File: rtl/pool_window_packer.sv
// Packs a raster-scan pixel stream into non-overlapping 2x2 windows for the ALU MaxPool op.
// Top-row pixel pairs are parked in a half-row line buffer until the bottom row completes them.
module pool_window_packer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic [PIX_W-1:0]   pix_i,
    input  logic               pix_vld_i,
    output logic               pix_rdy_o,
    output logic [4*PIX_W-1:0] win_o,
    output logic               win_vld_o,
    input  logic               win_rdy_i,
    output logic               win_last_o
);

    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic {ROW_TOP, ROW_BOT} state_t;

    state_t             state;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [PIX_W-1:0]   top_l;
    logic [PIX_W-1:0]   bot_l;
    logic [2*PIX_W-1:0] lbuf [HALF_W];

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [LW-1:0] lidx;

    // Room for a beat whenever the output register is empty or draining this cycle.
    assign pix_rdy_o = !win_vld_o || win_rdy_i;
    assign accept    = pix_vld_i && pix_rdy_o && !clr_i;
    assign col_last  = (col == COL_MAX);
    assign row_last  = (row == ROW_MAX);
    assign lidx      = LW'(col >> 1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ROW_TOP;
            col        <= '0;
            row        <= '0;
            top_l      <= '0;
            bot_l      <= '0;
            win_o      <= '0;
            win_vld_o  <= 1'b0;
            win_last_o <= 1'b0;
        end else if (clr_i) begin
            state      <= ROW_TOP;
            col        <= '0;
            row        <= '0;
            win_vld_o  <= 1'b0;
            win_last_o <= 1'b0;
        end else begin
            if (win_vld_o && win_rdy_i) begin
                win_vld_o  <= 1'b0;
                win_last_o <= 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                case (state)
                    ROW_TOP: begin
                        if (!col[0])
                            top_l <= pix_i;
                        if (col_last)
                            state <= ROW_BOT;
                    end
                    ROW_BOT: begin
                        if (!col[0]) begin
                            bot_l <= pix_i;
                        end else begin
                            // A load in the same cycle as a drain overrides the clear above.
                            win_o      <= {pix_i, bot_l, lbuf[lidx]};
                            win_vld_o  <= 1'b1;
                            win_last_o <= row_last && col_last;
                        end
                        if (col_last)
                            state <= ROW_TOP;
                    end
                    default: state <= ROW_TOP;
                endcase
            end
        end
    end

    // Line buffer holds no control state, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (accept && state == ROW_TOP && col[0])
            lbuf[lidx] <= {pix_i, top_l};
    end

endmodule
